sdram_pattern_tester: RTL and testbench

Avalon-MM master that sits directly upstream of nios_system_sdram and drives its az_*/za_* slave port. On start it writes a deterministic pattern over an inclusive address range, reads the range back with pipelined reads, and compares each returned word. It reports pass/fail, an error count and the first failing address, and serves as the board-level SDRAM self-test engine.

---
 rtl/sdram_pattern_tester_if.sv | 26 ++
 rtl/sdram_pattern_tester.sv | 196 +++++++++++++++++++
 tb/tb_sdram_pattern_tester.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_pattern_tester_if.sv
// Avalon-MM bus between the SDRAM pattern tester (master) and the SDRAM
// controller slave port (az_* toward the controller, za_* back from it).
interface sdram_pattern_tester_if #(
   parameter int ADDR_W = 22,
   parameter int DATA_W = 16,
   parameter int BE_W   = 2
);
   logic [ADDR_W-1:0] az_addr;
   logic [DATA_W-1:0] az_data;
   logic [BE_W-1:0]   az_be_n;
   logic              az_wr_n;
   logic              az_rd_n;
   logic [DATA_W-1:0] za_data;
   logic              za_valid;
   logic              za_waitrequest;

   modport master (
      output az_addr, az_data, az_be_n, az_wr_n, az_rd_n,
      input  za_data, za_valid, za_waitrequest
   );

   modport slave (
      input  az_addr, az_data, az_be_n, az_wr_n, az_rd_n,
      output za_data, za_valid, za_waitrequest
   );
endinterface

// File: rtl/sdram_pattern_tester.sv
// SDRAM self-test engine: writes expected(a) = a ^ SEED over an inclusive
// address range, reads it back with up to MAX_OUTSTANDING pipelined reads,
// and counts mismatches against the in-order read returns.
// Optional macro SDRAM_TESTER_INVERT_PASS_EN adds a second write/read pass
// over the same range using the bitwise-inverted pattern.
module sdram_pattern_tester #(
   parameter int          ADDR_W          = 22,
   parameter int          DATA_W          = 16,
   parameter int          BE_W            = 2,
   parameter int          MAX_OUTSTANDING = 4,
   parameter logic [15:0] SEED            = 16'hA5C3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     addr_start,
   input  logic [ADDR_W-1:0]     addr_end,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           err_count,
   output logic [ADDR_W-1:0]     first_err_addr,
   sdram_pattern_tester_if.master bus
);
   localparam int                CNT_W   = 4;
   localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTSTANDING);
   localparam logic [DATA_W-1:0] SEED_D  = DATA_W'(SEED);

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] start_q;
   logic [ADDR_W-1:0] end_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_inc;
   logic [ADDR_W-1:0] cmp_addr;
   logic [DATA_W-1:0] data_q;
   logic              wr_n_q;
   logic              rd_n_q;
   logic [CNT_W-1:0]  out_q;
   logic [CNT_W-1:0]  out_next;
   logic              wr_accept;
   logic              rd_accept;
   logic              valid_counted;
   logic              word_bad;
   logic              inv;

`ifdef SDRAM_TESTER_INVERT_PASS_EN
   logic              second_pass;
   assign inv = second_pass;
`else
   assign inv = 1'b0;
`endif

   function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                 input logic inv_en);
      pattern = a[DATA_W-1:0] ^ SEED_D ^ {DATA_W{inv_en}};
   endfunction

   assign bus.az_addr = addr_q;
   assign bus.az_data = data_q;
   assign bus.az_be_n = '0;
   assign bus.az_wr_n = wr_n_q;
   assign bus.az_rd_n = rd_n_q;

   assign wr_accept     = !wr_n_q && !bus.za_waitrequest;
   assign rd_accept     = !rd_n_q && !bus.za_waitrequest;
   assign valid_counted = bus.za_valid && (out_q != '0);
   assign word_bad      = bus.za_data != pattern(cmp_addr, inv);
   assign addr_inc      = addr_q + ADDR_W'(1);

   // Reads in flight after this edge; a return with nothing outstanding is stale and ignored.
   always_comb begin
      out_next = out_q;
      if (rd_accept && !valid_counted)
         out_next = out_q + CNT_W'(1);
      else if (!rd_accept && valid_counted)
         out_next = out_q - CNT_W'(1);
   end

   // Test sequencer: bus command generation, outstanding tracking and readback compare.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         start_q        <= '0;
         end_q          <= '0;
         addr_q         <= '0;
         cmp_addr       <= '0;
         data_q         <= '0;
         wr_n_q         <= 1'b1;
         rd_n_q         <= 1'b1;
         out_q          <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
`ifdef SDRAM_TESTER_INVERT_PASS_EN
         second_pass    <= 1'b0;
`endif
      end else begin
         out_q <= out_next;
         if (valid_counted) begin
            cmp_addr <= cmp_addr + ADDR_W'(1);
            if (word_bad) begin
               if (err_count != 16'hFFFF)
                  err_count <= err_count + 16'd1;
               if (err_count == 16'd0)
                  first_err_addr <= cmp_addr;
            end
         end
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  start_q        <= addr_start;
                  end_q          <= addr_end;
                  cmp_addr       <= addr_start;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  pass           <= 1'b0;
                  done           <= 1'b0;
                  busy           <= 1'b1;
                  if (addr_end < addr_start) begin
                     // Empty range: pass through DRAIN (nothing outstanding) straight to DONE.
`ifdef SDRAM_TESTER_INVERT_PASS_EN
                     second_pass <= 1'b1;
`endif
                     state <= DRAIN;
                  end else begin
`ifdef SDRAM_TESTER_INVERT_PASS_EN
                     second_pass <= 1'b0;
`endif
                     addr_q <= addr_start;
                     data_q <= pattern(addr_start, 1'b0);
                     wr_n_q <= 1'b0;
                     state  <= WRITE;
                  end
               end
            end
            WRITE: begin
               if (wr_accept) begin
                  if (addr_q == end_q) begin
                     wr_n_q <= 1'b1;
                     rd_n_q <= 1'b0;
                     addr_q <= start_q;
                     state  <= READ;
                  end else begin
                     addr_q <= addr_inc;
                     data_q <= pattern(addr_inc, inv);
                  end
               end
            end
            READ: begin
               if (!rd_n_q) begin
                  if (!bus.za_waitrequest) begin
                     if (addr_q == end_q) begin
                        rd_n_q <= 1'b1;
                        state  <= DRAIN;
                     end else begin
                        addr_q <= addr_inc;
                        rd_n_q <= (out_next < MAX_CNT) ? 1'b0 : 1'b1;
                     end
                  end
               end else if (out_next < MAX_CNT) begin
                  rd_n_q <= 1'b0;
               end
            end
            DRAIN: begin
               if (out_q == '0) begin
`ifdef SDRAM_TESTER_INVERT_PASS_EN
                  if (!second_pass) begin
                     second_pass <= 1'b1;
                     addr_q      <= start_q;
                     cmp_addr    <= start_q;
                     data_q      <= pattern(start_q, 1'b1);
                     wr_n_q      <= 1'b0;
                     state       <= WRITE;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_count == 16'd0);
                     state <= DONE;
                  end
`else
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == 16'd0);
                  state <= DONE;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed self-checking bench for sdram_pattern_tester with a small
// SDRAM controller model (configurable read latency, stalls, corruption).
module tb_sdram_pattern_tester;
   localparam int ADDR_W  = 22;
   localparam int DATA_W  = 16;
   localparam int MAX_OUT = 4;
`ifdef SDRAM_TESTER_INVERT_PASS_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] addr_start = '0;
   logic [ADDR_W-1:0] addr_end = '0;
   logic              busy;
   logic              done;
   logic              pass;
   logic [15:0]       err_count;
   logic [ADDR_W-1:0] first_err_addr;

   int checks = 0;
   int passes = 0;

   sdram_pattern_tester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(2)) bus();

   sdram_pattern_tester dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .addr_start(addr_start),
      .addr_end(addr_end),
      .busy(busy),
      .done(done),
      .pass(pass),
      .err_count(err_count),
      .first_err_addr(first_err_addr),
      .bus(bus)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem [256];
   logic [DATA_W-1:0] rq_data [$];
   int                rq_due [$];
   int cyc = 0, latency = 3, outst = 0, max_outst = 0;
   int writes = 0, reads = 0, act_cycles = 0, both_low = 0, rd_at_limit = 0;
   int wr_bad = 0, acc10 = 0, stall_left = 0, stall_seen = 0, stall_bad = 0;
   int inject_left = 0, first_wr_cyc = 0, last_wr_cyc = 0;
   logic [ADDR_W-1:0] exp_wa = '0, range_lo = '0, stall_addr = '0;
   logic [ADDR_W-1:0] corrupt_a = '0, corrupt_b = '0;
   logic [DATA_W-1:0] data_at5 = '0, first_wr_data = '0;
   logic garble = 1'b0, second_seen = 1'b0, have_corrupt = 1'b0;

   function automatic logic [DATA_W-1:0] expPattern(input logic [ADDR_W-1:0] a,
                                                    input logic inv_en);
      logic [DATA_W-1:0] p;
      p = a[DATA_W-1:0] ^ 16'hA5C3;
      return inv_en ? ~p : p;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      if (obs !== exp)
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      else
         passes++;
   endtask

   task automatic resetModel(input logic [ADDR_W-1:0] lo);
      writes = 0; reads = 0; act_cycles = 0; both_low = 0; rd_at_limit = 0;
      wr_bad = 0; acc10 = 0; stall_left = 0; stall_seen = 0; stall_bad = 0;
      max_outst = 0; exp_wa = lo; range_lo = lo; second_seen = 1'b0;
      have_corrupt = 1'b0; garble = 1'b0; data_at5 = '0; first_wr_data = '0;
   endtask

   task automatic applyStimulus(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
      @(posedge clk); #1;
      addr_start = s;
      addr_end   = e;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic waitDone(input int budget, input string tag);
      int n;
      n = 0;
      while (!done && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
   endtask

   // Controller model: mid-cycle it decides waitrequest, presents due read data and records accepts.
   always @(negedge clk) begin
      logic              wreq;
      logic [DATA_W-1:0] rd;
      cyc++;
      wreq = 1'b0;
      if (stall_left > 0 && !bus.az_wr_n && bus.az_addr == stall_addr) begin
         wreq = 1'b1;
         stall_seen++;
         stall_left--;
         if (bus.az_data !== expPattern(stall_addr, 1'b0)) stall_bad++;
      end
      bus.za_waitrequest = wreq;
      if (!bus.az_wr_n || !bus.az_rd_n) act_cycles++;
      if (!bus.az_wr_n && !bus.az_rd_n) both_low++;
      if (!bus.az_rd_n && outst >= MAX_OUT) rd_at_limit++;
      bus.za_valid = 1'b0;
      bus.za_data  = '0;
      if (inject_left > 0) begin
         bus.za_valid = 1'b1;
         bus.za_data  = 16'hDEAD;
         inject_left--;
      end else if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
         void'(rq_due.pop_front());
         bus.za_data  = rq_data.pop_front();
         bus.za_valid = 1'b1;
         if (outst > 0) outst--;
      end
      if (!wreq && !bus.az_wr_n) begin
         if (reads > 0 && !second_seen) begin
            second_seen = 1'b1;
            exp_wa      = range_lo;
         end
         if (bus.az_addr !== exp_wa || bus.az_data !== expPattern(exp_wa, second_seen)) wr_bad++;
         mem[bus.az_addr[7:0]] = bus.az_data;
         if (writes == 0) begin
            first_wr_cyc  = cyc;
            first_wr_data = bus.az_data;
         end
         if (!second_seen) last_wr_cyc = cyc;
         if (!second_seen && bus.az_addr == 22'd5) data_at5 = bus.az_data;
         if (bus.az_addr == 22'd10) acc10++;
         exp_wa = exp_wa + 22'd1;
         writes++;
      end
      if (!wreq && !bus.az_rd_n) begin
         rd = mem[bus.az_addr[7:0]];
         if (have_corrupt && (bus.az_addr == corrupt_a || bus.az_addr == corrupt_b))
            rd = rd ^ 16'h0001;
         if (garble) rd = ~rd;
         rq_data.push_back(rd);
         rq_due.push_back(cyc + latency);
         outst++;
         if (outst > max_outst) max_outst = outst;
         reads++;
      end
      if (reset) outst = 0;
   end

   // Absolute time limit so a stuck design still ends the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      int n;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_pass", {31'd0, pass}, 32'd0);
      checkOutput("rst_err", {16'd0, err_count}, 32'd0);
      checkOutput("rst_first", {10'd0, first_err_addr}, 32'd0);
      checkOutput("rst_wr_n", {31'd0, bus.az_wr_n}, 32'd1);
      checkOutput("rst_rd_n", {31'd0, bus.az_rd_n}, 32'd1);
      checkOutput("rst_addr", {10'd0, bus.az_addr}, 32'd0);
      checkOutput("rst_data", {16'd0, bus.az_data}, 32'd0);
      checkOutput("rst_be_n", {30'd0, bus.az_be_n}, 32'd0);
      reset = 1'b0;

      // Full 0..127 sweep, no stalls, latency 3.
      latency = 3;
      resetModel(22'd0);
      applyStimulus(22'd0, 22'd127);
      checkOutput("t1_busy", {31'd0, busy}, 32'd1);
      waitDone(3000, "t1");
      checkOutput("t1_pass", {31'd0, pass}, 32'd1);
      checkOutput("t1_err", {16'd0, err_count}, 32'd0);
      checkOutput("t1_writes", writes, 128 * PASSES);
      checkOutput("t1_reads", reads, 128 * PASSES);
      checkOutput("t1_wr_order", wr_bad, 0);
      checkOutput("t1_data_at5", {16'd0, data_at5}, 32'h0000A5C6);
      checkOutput("t1_b2b_span", last_wr_cyc - first_wr_cyc, 127);
      checkOutput("t1_both_low", both_low, 0);
      checkOutput("t1_busy_end", {31'd0, busy}, 32'd0);

      // Four-cycle stall on the write to address 10.
      resetModel(22'd0);
      stall_addr = 22'd10;
      stall_left = 4;
      applyStimulus(22'd0, 22'd31);
      waitDone(2000, "t2");
      checkOutput("t2_stall_cycles", stall_seen, 4);
      checkOutput("t2_stall_stable", stall_bad, 0);
      checkOutput("t2_acc10", acc10, PASSES);
      checkOutput("t2_wr_order", wr_bad, 0);
      checkOutput("t2_writes", writes, 32 * PASSES);
      checkOutput("t2_pass", {31'd0, pass}, 32'd1);

      // Corrupted readback at 33 and 40.
      resetModel(22'd0);
      corrupt_a    = 22'd33;
      corrupt_b    = 22'd40;
      have_corrupt = 1'b1;
      applyStimulus(22'd0, 22'd63);
      waitDone(2000, "t3");
      checkOutput("t3_err", {16'd0, err_count}, 2 * PASSES);
      checkOutput("t3_first", {10'd0, first_err_addr}, 32'd33);
      checkOutput("t3_pass", {31'd0, pass}, 32'd0);

      // Long read latency against the outstanding limit.
      latency = 10;
      resetModel(22'd0);
      applyStimulus(22'd0, 22'd15);
      waitDone(2000, "t4");
      checkOutput("t4_max_outst", max_outst, MAX_OUT);
      checkOutput("t4_rd_at_limit", rd_at_limit, 0);
      checkOutput("t4_reads", reads, 16 * PASSES);
      checkOutput("t4_pass", {31'd0, pass}, 32'd1);

      // Empty range: no bus activity, done two cycles after start.
      latency = 3;
      resetModel(22'd20);
      applyStimulus(22'd20, 22'd10);
      checkOutput("t5_done_early", {31'd0, done}, 32'd0);
      checkOutput("t5_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      checkOutput("t5_done", {31'd0, done}, 32'd1);
      checkOutput("t5_pass", {31'd0, pass}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("t5_activity", act_cycles, 0);

      // Single-word range at the top of the address space.
      resetModel('1);
      applyStimulus('1, '1);
      waitDone(200, "t5b");
      checkOutput("t5b_writes", writes, PASSES);
      checkOutput("t5b_reads", reads, PASSES);
      checkOutput("t5b_data", {16'd0, first_wr_data}, 32'h00005A3C);
      checkOutput("t5b_pass", {31'd0, pass}, 32'd1);

      // Reset with reads in flight, then stale returns.
      latency = 10;
      resetModel(22'd0);
      applyStimulus(22'd0, 22'd15);
      n = 0;
      while (outst != 3 && n < 400) begin
         @(posedge clk); #2;
         n++;
      end
      checkOutput("t6_inflight", outst, 3);
      reset  = 1'b1;
      garble = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("t6_busy", {31'd0, busy}, 32'd0);
      checkOutput("t6_wr_n", {31'd0, bus.az_wr_n}, 32'd1);
      checkOutput("t6_rd_n", {31'd0, bus.az_rd_n}, 32'd1);
      checkOutput("t6_addr", {10'd0, bus.az_addr}, 32'd0);
      inject_left = 3;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("t6_stale_err", {16'd0, err_count}, 32'd0);
      checkOutput("t6_stale_first", {10'd0, first_err_addr}, 32'd0);
      checkOutput("t6_done", {31'd0, done}, 32'd0);
      checkOutput("t6_queue_empty", rq_due.size(), 0);
      latency = 3;
      resetModel(22'd0);
      applyStimulus(22'd0, 22'd7);
      waitDone(500, "t6b");
      checkOutput("t6b_pass", {31'd0, pass}, 32'd1);
      checkOutput("t6b_err", {16'd0, err_count}, 32'd0);
      checkOutput("t6b_writes", writes, 8 * PASSES);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
